// File: rtl/serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares one AVR serial transmitter between four byte-stream requesters.
// A requester is granted round-robin and keeps the grant for a whole message
// (up to and including the byte flagged with req_last). After each byte the
// arbiter pauses so the transmitter has time to raise tx_busy before the next
// byte is offered. A granted requester that stalls (valid low, transmitter
// idle) for TIMEOUT cycles loses the grant.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req_valid    [3:0]  requester i presents a byte
//   req_data     [31:0] byte of requester i on bits [8i+7:8i]
//   req_last     [3:0]  requester i's byte ends its message
//   req_ready    [3:0]  requester i's byte is accepted this cycle
//   grant        [3:0]  one-hot registered owner of the channel, 0 when free
//   tx_data      [7:0]  byte to the transmitter, held until the next transfer
//   new_tx_data         one-cycle strobe qualifying tx_data
//   tx_busy             transmitter busy (includes AVR Rx-full back-pressure)
// ---------------------------------------------------------------------------
module serial_tx_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  owner;
    logic [1:0]  last_grant;
    logic        last_latched;
    logic [15:0] timeout_cnt;

    logic [1:0]  rr_pick;
    logic        rr_found;
    logic [1:0]  cand;
    logic        sel_valid;
    logic [7:0]  sel_data;
    logic        sel_last;

    // Round-robin search starting one past the previous owner, so the
    // requester that just finished has the lowest priority.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        cand     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + 2'(k);
            if (!rr_found && req_valid[cand]) begin
                rr_pick  = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign sel_valid = req_valid[owner];
    assign sel_data  = req_data[{owner, 3'b000} +: 8];
    assign sel_last  = req_last[owner];

    // grant is one-hot on the owner throughout SEND, so it doubles as the
    // ready mask.
    assign req_ready = (state == SEND && !tx_busy) ? grant : 4'b0000;

    // GAP is entered together with the tx strobe and held one further cycle
    // (while new_tx_data is already low) regardless of tx_busy; that second
    // cycle is when the transmitter raises busy in response to the strobe,
    // which keeps consecutive strobes at least three cycles apart.
    // The stall counter only advances while the owner has nothing to offer
    // and the transmitter is free; back-pressure never times a requester out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= 2'd0;
            grant        <= 4'b0000;
            last_grant   <= 2'd3;
            last_latched <= 1'b0;
            timeout_cnt  <= 16'd0;
            tx_data      <= 8'h00;
            new_tx_data  <= 1'b0;
        end else begin
            new_tx_data <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner       <= rr_pick;
                        grant       <= 4'b0001 << rr_pick;
                        timeout_cnt <= 16'd0;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        if (sel_valid) begin
                            tx_data      <= sel_data;
                            new_tx_data  <= 1'b1;
                            last_latched <= sel_last;
                            timeout_cnt  <= 16'd0;
                            state        <= GAP;
                        end else if (timeout_cnt == TIMEOUT_LAST) begin
                            grant       <= 4'b0000;
                            last_grant  <= owner;
                            timeout_cnt <= 16'd0;
                            state       <= IDLE;
                        end else begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                    end
                end
                GAP: begin
                    if (!new_tx_data) begin
                        if (last_latched) begin
                            grant      <= 4'b0000;
                            last_grant <= owner;
                            state      <= IDLE;
                        end else begin
                            timeout_cnt <= 16'd0;
                            state       <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_arbiter
//
// Four queue-driven requesters feed the arbiter. A message-level reference
// model (owner / cool-down / stall count) predicts grant, req_ready, tx_data
// and new_tx_data every cycle; directed scenarios pin exact cycle timings
// with hand-computed literals; a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_serial_tx_arbiter;

    localparam int TIMEOUT = 8;
    localparam int HIST    = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_last = 4'b0000;
    logic        tx_busy = 1'b0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        new_tx_data;

    serial_tx_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_data    (tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy    (tx_busy)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Each entry is {last, data}
    logic [8:0] src_q [4][$];
    logic [3:0] hold = 4'b0000;
    int         hold_cnt [4];
    logic [3:0] src_fire;
    logic [8:0] head;

    int         cyc = 0;
    logic [3:0] hist_grant [HIST];
    logic [3:0] hist_valid [HIST];

    typedef struct {
        int         c;
        logic [7:0] d;
        logic [3:0] g;
    } strobe_t;
    strobe_t strobes[$];

    // Reference model: who owns the channel, how many cool-down cycles remain
    // after a byte, whether that byte closed the message, and how long the
    // owner has stalled.
    bit         model_on = 1'b0;
    int         m_owner = -1;
    int         m_last = 3;
    int         m_gap = 0;
    int         m_cnt = 0;
    bit         m_ending = 1'b0;
    logic [3:0] m_grant = 4'b0000;
    logic       m_strobe = 1'b0;
    logic [7:0] m_data = 8'h00;
    logic [3:0] exp_ready;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] data, input logic last);
        src_q[r].push_back({last, data});
    endtask

    // Requesters present the head of their queue and pop it once accepted.
    always @(posedge clk) begin : source
        src_fire = rst ? 4'b0000 : (req_valid & req_ready);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (src_fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0 && !hold[i]) begin
                head = src_q[i][0];
                req_valid[i]        = 1'b1;
                req_data[i*8 +: 8]  = head[7:0];
                req_last[i]         = head[8];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    end

    // Model update: one step of the arbitration rules per clock.
    always @(posedge clk) begin : model
        if (rst) begin
            m_owner  = -1;
            m_last   = 3;
            m_gap    = 0;
            m_cnt    = 0;
            m_ending = 1'b0;
            m_strobe = 1'b0;
            m_data   = 8'h00;
            model_on = 1'b1;
        end else begin
            m_strobe = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= 4; k++)
                    if (m_owner < 0 && req_valid[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
                m_cnt = 0;
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) begin
                    if (m_ending) begin
                        m_last  = m_owner;
                        m_owner = -1;
                    end else begin
                        m_cnt = 0;
                    end
                end
            end else if (!tx_busy) begin
                if (req_valid[m_owner]) begin
                    m_data   = req_data[m_owner*8 +: 8];
                    m_strobe = 1'b1;
                    m_ending = req_last[m_owner];
                    m_gap    = 2;
                    m_cnt    = 0;
                end else if (m_cnt == TIMEOUT - 1) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        m_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    end

    // Every cycle: log history and compare the DUT against the model.
    always @(negedge clk) begin : compare
        cyc++;
        hist_grant[cyc % HIST] = grant;
        hist_valid[cyc % HIST] = req_valid;
        if (new_tx_data === 1'b1) strobes.push_back('{c: cyc, d: tx_data, g: grant});
        if (model_on) begin
            exp_ready = (m_owner >= 0 && m_gap == 0 && !tx_busy) ? m_grant : 4'b0000;
            checkOutput("grant", 32'(grant), 32'(m_grant));
            checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
            checkOutput("new_tx_data", 32'(new_tx_data), 32'(m_strobe));
            checkOutput("tx_data", 32'(tx_data), 32'(m_data));
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_strobes(input int n, input int limit, input string name);
        int k = 0;
        while (strobes.size() < n && k < limit) begin
            wait_neg(1);
            k++;
        end
        checkOutput(name, 32'(strobes.size()), 32'(n));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst     = 1'b1;
        tx_busy = 1'b0;
        hold    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            hold_cnt[i] = 0;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        strobes.delete();
    endtask

    task automatic check_ids(input string name, input int n, input logic [3:0] ids [8], input logic [7:0] dat [8]);
        if (strobes.size() >= n) begin
            for (int k = 0; k < n; k++) begin
                checkOutput({name, "_grant"}, 32'(strobes[k].g), 32'(ids[k]));
                checkOutput({name, "_data"}, 32'(strobes[k].d), 32'(dat[k]));
            end
        end
    endtask

    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int n, s, f, start, kept, seen;
        logic [3:0] ids [8];
        logic [7:0] dat [8];

        // Reset values
        repeat (2) @(posedge clk);
        wait_neg(0);
        @(negedge clk); #1;
        checkOutput("reset_grant", 32'(grant), 32'h0);
        checkOutput("reset_strobe", 32'(new_tx_data), 32'h0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_neg(1);
        checkOutput("ready_after_reset", 32'(req_ready), 32'h0);

        // Single requester "Hi"
        $display("[TB] single requester");
        do_reset();
        applyStimulus(1, 8'h48, 1'b0);
        applyStimulus(1, 8'h69, 1'b1);
        start = cyc;
        wait_strobes(2, 60, "hi_strobes");
        n = -1;
        for (int c = start + 1; c <= cyc; c++)
            if (n < 0 && hist_valid[c % HIST][1]) n = c;
        wait_neg(4);
        if (strobes.size() >= 2) begin
            checkOutput("hi_grant_latency", 32'(hist_grant[(n + 1) % HIST]), 32'h2);
            checkOutput("hi_strobe_latency", 32'(strobes[0].c), 32'(n + 2));
            checkOutput("hi_byte0", 32'(strobes[0].d), 32'h48);
            checkOutput("hi_spacing", 32'(strobes[1].c - strobes[0].c), 32'd3);
            checkOutput("hi_byte1", 32'(strobes[1].d), 32'h69);
            checkOutput("hi_grant_released", 32'(hist_grant[(strobes[1].c + 2) % HIST]), 32'h0);
        end

        // Contention: all four one-byte messages, then requester 0 again
        $display("[TB] contention");
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus(i, 8'hA0 + 8'(i), 1'b1);
        applyStimulus(0, 8'hB0, 1'b1);
        wait_strobes(5, 100, "rr_strobes");
        ids = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
        dat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'h0, 8'h0, 8'h0};
        check_ids("rr", 5, ids, dat);

        // Busy stall with TIMEOUT=8
        $display("[TB] busy stall");
        do_reset();
        tx_busy = 1'b1;
        applyStimulus(2, 8'h5A, 1'b1);
        seen = 0;
        while (grant !== 4'h4 && seen < 20) begin
            wait_neg(1);
            seen++;
        end
        checkOutput("stall_granted", 32'(grant), 32'h4);
        kept = 0;
        for (int k = 0; k < 50; k++) begin
            wait_neg(1);
            if (grant === 4'h4) kept++;
        end
        checkOutput("stall_no_strobe", 32'(strobes.size()), 32'd0);
        checkOutput("stall_grant_kept", 32'(kept), 32'd50);
        @(posedge clk); #1;
        tx_busy = 1'b0;
        f = cyc + 1;
        wait_strobes(1, 10, "stall_strobe");
        if (strobes.size() >= 1) begin
            checkOutput("stall_release_timing", 32'(strobes[0].c), 32'(f + 1));
            checkOutput("stall_byte", 32'(strobes[0].d), 32'h5A);
        end

        // Timeout: requester 2 stalls mid-message, requester 3 waits
        $display("[TB] timeout");
        do_reset();
        applyStimulus(2, 8'h11, 1'b0);
        applyStimulus(3, 8'h33, 1'b1);
        wait_strobes(1, 20, "to_first_strobe");
        if (strobes.size() >= 1) begin
            s = strobes[0].c;
            checkOutput("to_first_owner", 32'(strobes[0].g), 32'h4);
            while (cyc < s + 12) wait_neg(1);
            checkOutput("to_grant_held", 32'(hist_grant[(s + 9) % HIST]), 32'h4);
            checkOutput("to_grant_dropped", 32'(hist_grant[(s + 10) % HIST]), 32'h0);
            checkOutput("to_next_owner", 32'(hist_grant[(s + 11) % HIST]), 32'h8);
            wait_strobes(2, 20, "to_second_strobe");
            if (strobes.size() >= 2) checkOutput("to_second_byte", 32'(strobes[1].d), 32'h33);
        end

        // Message lock
        $display("[TB] message lock");
        do_reset();
        applyStimulus(0, 8'h01, 1'b0);
        applyStimulus(0, 8'h02, 1'b0);
        applyStimulus(0, 8'h03, 1'b1);
        applyStimulus(1, 8'h04, 1'b1);
        wait_strobes(4, 80, "lock_strobes");
        ids = '{4'h1, 4'h1, 4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
        dat = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0};
        check_ids("lock", 4, ids, dat);

        // Reset mid-message
        $display("[TB] reset mid-message");
        do_reset();
        for (int k = 0; k < 4; k++) applyStimulus(1, 8'hC0 + 8'(k), (k == 3));
        wait_strobes(1, 20, "rm_first_strobe");
        do_reset();
        wait_neg(1);
        checkOutput("rm_grant", 32'(grant), 32'h0);
        checkOutput("rm_strobe", 32'(new_tx_data), 32'h0);
        wait_neg(10);
        checkOutput("rm_no_resume", 32'(strobes.size()), 32'd0);
        applyStimulus(3, 8'hD3, 1'b1);
        applyStimulus(0, 8'hD0, 1'b1);
        wait_strobes(2, 40, "rm_strobes");
        ids = '{4'h1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        dat = '{8'hD0, 8'hD3, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
        check_ids("rm", 2, ids, dat);

        // Randomized traffic against the model
        $display("[TB] random traffic");
        do_reset();
        repeat (1500) begin
            @(posedge clk); #1;
            rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (src_q[i].size() < 4 && $urandom_range(0, 3) == 0) begin
                    n = $urandom_range(1, 4);
                    for (int k = 0; k < n; k++) applyStimulus(i, 8'($urandom), (k == n - 1));
                end
                if (hold_cnt[i] > 0) hold_cnt[i]--;
                else if ($urandom_range(0, 15) == 0) hold_cnt[i] = $urandom_range(1, 14);
                hold[i] = (hold_cnt[i] > 0);
            end
            tx_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                for (int i = 0; i < 4; i++) src_q[i].delete();
            end
        end
        do_reset();
        wait_neg(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
